// File: rtl/cv32e40p_vector_load_unit_if.sv
// Bundled command, data-memory and vector-register-file signals of the vector load unit.
// Signal suffixes are from the load unit's point of view; the slave modport is the unit itself.
interface cv32e40p_vector_load_unit_if;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [31:0]  cmd_addr_i;
  logic [3:0]   cmd_vd_i;
  logic [3:0]   cmd_lane_mask_i;

  logic         data_req_o;
  logic         data_gnt_i;
  logic [31:0]  data_addr_o;
  logic         data_rvalid_i;
  logic [31:0]  data_rdata_i;
  logic         data_err_i;

  logic         vrf_we_o;
  logic [3:0]   vrf_waddr_o;
  logic [127:0] vrf_wdata_o;
  logic [3:0]   vrf_wmask_o;

  logic         busy_o;
  logic         done_o;
  logic         err_o;

  modport slave (
    input  cmd_valid_i, cmd_addr_i, cmd_vd_i, cmd_lane_mask_i,
    input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
    output cmd_ready_o, data_req_o, data_addr_o,
    output vrf_we_o, vrf_waddr_o, vrf_wdata_o, vrf_wmask_o,
    output busy_o, done_o, err_o
  );

  modport master (
    output cmd_valid_i, cmd_addr_i, cmd_vd_i, cmd_lane_mask_i,
    output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
    input  cmd_ready_o, data_req_o, data_addr_o,
    input  vrf_we_o, vrf_waddr_o, vrf_wdata_o, vrf_wmask_o,
    input  busy_o, done_o, err_o
  );
endinterface

// File: rtl/cv32e40p_vector_load_unit.sv
// Vector load unit: fetches the selected 32-bit lanes of a 128-bit vector over OBI
// and writes the assembled vector to the vector register file in one beat.
//
// state | meaning
// IDLE  | ready for a command
// REQ   | issuing word requests for the remaining selected lanes
// WAIT  | all requests granted, draining responses
// WRITE | one-cycle completion with register-file write (suppressed on bus error)
// DONE  | one-cycle completion without memory traffic (illegal vd or empty mask)
module cv32e40p_vector_load_unit #(
  parameter int NUM_VREGS       = 11,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cv32e40p_vector_load_unit_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_e;

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [3:0]       vd_q, vd_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0]       iss_q, iss_d;
  logic [3:0]       rsp_q, rsp_d;
  logic [2:0]       out_q, out_d;
  logic             err_q, err_d;
  logic [3:0][31:0] buf_q, buf_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [3:0]       waddr_q, waddr_d;
  logic [127:0]     wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic             done_q, done_d;
  logic             erro_q, erro_d;

  logic             hs, gnt_acc, rsp_acc;
  logic [1:0]       rsp_lane, iss_lane;

  function automatic logic [1:0] first_lane(input logic [3:0] m);
    logic [1:0] l;
    l = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) l = 2'(i);
    end
    return l;
  endfunction

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    vd_d     = vd_q;
    mask_d   = mask_q;
    iss_d    = iss_q;
    rsp_d    = rsp_q;
    err_d    = err_q;
    buf_d    = buf_q;
    req_d    = req_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    done_d   = 1'b0;
    erro_d   = 1'b0;

    hs       = bus.cmd_valid_i && (state_q == IDLE);
    gnt_acc  = req_q && bus.data_gnt_i;
    // A response with nothing outstanding is a protocol violation and is dropped.
    rsp_acc  = bus.data_rvalid_i && (out_q != 3'd0);
    rsp_lane = first_lane(rsp_q);
    iss_lane = first_lane(iss_q);

    unique case ({gnt_acc, rsp_acc})
      2'b10:   out_d = out_q + 3'd1;
      2'b01:   out_d = out_q - 3'd1;
      default: out_d = out_q;
    endcase

    if (rsp_acc) begin
      buf_d[rsp_lane] = bus.data_rdata_i;
      rsp_d           = rsp_q & ~(4'b0001 << rsp_lane);
      if (bus.data_err_i) err_d = 1'b1;
    end
    if (gnt_acc) iss_d = iss_q & ~(4'b0001 << iss_lane);

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          base_d = {bus.cmd_addr_i[31:2], 2'b00};
          vd_d   = bus.cmd_vd_i;
          mask_d = bus.cmd_lane_mask_i;
          iss_d  = bus.cmd_lane_mask_i;
          rsp_d  = bus.cmd_lane_mask_i;
          buf_d  = '0;
          err_d  = 1'b0;
          if (int'(bus.cmd_vd_i) >= NUM_VREGS) begin
            err_d   = 1'b1;
            erro_d  = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (bus.cmd_lane_mask_i == 4'd0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (gnt_acc && (iss_d == 4'd0)) state_d = WAIT;
      end
      WAIT: begin
        if (rsp_d == 4'd0) begin
          state_d = WRITE;
          done_d  = 1'b1;
          erro_d  = err_d;
          we_d    = !err_d;
          if (!err_d) begin
            waddr_d = vd_q;
            wdata_d = buf_d;
            wmask_d = mask_q;
          end
        end
      end
      WRITE:   state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An ungranted request keeps req and addr frozen; otherwise issue the next lane if credit allows.
    if (req_q && !bus.data_gnt_i) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else if ((state_d == REQ) && (iss_d != 4'd0) && (int'(out_d) < MAX_OUTSTANDING)) begin
      req_d  = 1'b1;
      addr_d = base_d + {28'd0, first_lane(iss_d), 2'b00};
    end else begin
      req_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      vd_q    <= '0;
      mask_q  <= '0;
      iss_q   <= '0;
      rsp_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      buf_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      done_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      vd_q    <= vd_d;
      mask_q  <= mask_d;
      iss_q   <= iss_d;
      rsp_q   <= rsp_d;
      out_q   <= out_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      done_q  <= done_d;
      erro_q  <= erro_d;
    end
  end

  assign bus.cmd_ready_o = (state_q == IDLE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.data_req_o  = req_q;
  assign bus.data_addr_o = addr_q;
  assign bus.vrf_we_o    = we_q;
  assign bus.vrf_waddr_o = waddr_q;
  assign bus.vrf_wdata_o = wdata_q;
  assign bus.vrf_wmask_o = wmask_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = erro_q;

endmodule

// File: tb/tb_cv32e40p_vector_load_unit.sv
// Self-checking bench for the vector load unit: a delay-configurable memory responder
// plus a lane-level reference model of the expected requests and register write.
module tb_cv32e40p_vector_load_unit;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] PAT = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40p_vector_load_unit_if bus();

  cv32e40p_vector_load_unit #(.NUM_VREGS(11), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
    logic        err;
  } rsp_t;

  rsp_t        rq[$];
  logic [31:0] req_addrs[$];
  int gnt_delay = 0, rsp_delay = 1, err_idx = -1;
  int gw = 0, grant_idx = 0;
  int first_req_cyc = -1, we_cnt = 0, we_cyc = -1, done_cnt = 0, done_cyc = -1;
  logic [3:0] we_addr, we_mask;
  logic [127:0] we_data;
  logic done_err;
  int viol = 0, out_cnt = 0, out_max = 0;
  logic prev_req = 1'b0, prev_gnt = 1'b0;
  logic [31:0] prev_addr = '0;

  // Memory responder and output monitor, acting 1 time unit after each rising edge.
  initial begin
    rsp_t e;
    bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0;
    bus.data_rdata_i = '0; bus.data_err_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.vrf_we_o) begin
        we_cnt++; we_cyc = cyc;
        we_addr = bus.vrf_waddr_o; we_data = bus.vrf_wdata_o; we_mask = bus.vrf_wmask_o;
      end
      if (bus.done_o) begin done_cnt++; done_cyc = cyc; done_err = bus.err_o; end
      if (bus.data_req_o && prev_req && !prev_gnt && (bus.data_addr_o !== prev_addr)) viol++;
      if (bus.data_req_o && first_req_cyc < 0) first_req_cyc = cyc;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        bus.data_rvalid_i = 1'b1; bus.data_rdata_i = rq[0].addr ^ PAT; bus.data_err_i = rq[0].err;
        void'(rq.pop_front());
      end else begin
        bus.data_rvalid_i = 1'b0; bus.data_rdata_i = '0; bus.data_err_i = 1'b0;
      end
      bus.data_gnt_i = 1'b0;
      if (bus.data_req_o === 1'b1) begin
        if (gw >= gnt_delay) begin
          bus.data_gnt_i = 1'b1; gw = 0;
          req_addrs.push_back(bus.data_addr_o);
          e.addr = bus.data_addr_o; e.due = cyc + rsp_delay; e.err = (grant_idx == err_idx);
          rq.push_back(e);
          grant_idx++;
        end else gw++;
      end
      out_cnt = out_cnt + (bus.data_gnt_i ? 1 : 0) - (bus.data_rvalid_i ? 1 : 0);
      if (out_cnt < 0) out_cnt = 0;
      if (out_cnt > out_max) out_max = out_cnt;
      prev_req = bus.data_req_o; prev_gnt = bus.data_gnt_i; prev_addr = bus.data_addr_o;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic clear_mon();
    req_addrs.delete();
    first_req_cyc = -1; we_cnt = 0; we_cyc = -1; done_cnt = 0; done_cyc = -1;
    viol = 0; out_max = 0; grant_idx = 0; gw = 0;
  endtask

  function automatic logic [31:0] lane_addr(input logic [31:0] base, input int i);
    return (base & 32'hFFFF_FFFC) + 32'(4 * i);
  endfunction

  function automatic logic [127:0] model_vec(input logic [31:0] base, input logic [3:0] mask);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) if (mask[i]) v[32*i +: 32] = lane_addr(base, i) ^ PAT;
    return v;
  endfunction

  task automatic run_cmd(input logic [31:0] base, input logic [3:0] vd, input logic [3:0] mask,
                         output int hs);
    for (int i = 0; i < 50 && !bus.cmd_ready_o; i++) tick();
    total++;
    if (!bus.cmd_ready_o) begin bad++; $display("FAIL cmd_ready timeout: got 0 want 1"); end
    clear_mon();
    bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = base; bus.cmd_vd_i = vd; bus.cmd_lane_mask_i = mask;
    hs = cyc;
    tick();
    bus.cmd_valid_i = 1'b0;
    for (int i = 0; i < 300 && done_cnt == 0; i++) tick();
    total++;
    if (done_cnt == 0) begin bad++; $display("FAIL done timeout: got none want done_o"); end
  endtask

  task automatic test_reset();
    total++;
    if ({bus.data_req_o, bus.vrf_we_o, bus.busy_o, bus.done_o, bus.err_o} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000",
        {bus.data_req_o, bus.vrf_we_o, bus.busy_o, bus.done_o, bus.err_o});
    end
    total++;
    if ({bus.data_addr_o, bus.vrf_waddr_o, bus.vrf_wmask_o, bus.vrf_wdata_o} !== '0) begin
      bad++; $display("FAIL reset_data: got addr=%h waddr=%h wmask=%h wdata=%h want all 0",
        bus.data_addr_o, bus.vrf_waddr_o, bus.vrf_wmask_o, bus.vrf_wdata_o);
    end
    total++;
    if (bus.cmd_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready_o); end
  endtask

  task automatic test_full_mask();
    int hs;
    logic [127:0] want;
    gnt_delay = 0; rsp_delay = 1; err_idx = -1;
    want = {32'hA5A5B5A9, 32'hA5A5B5AD, 32'hA5A5B5A1, 32'hA5A5B5A5};
    run_cmd(32'h1000, 4'd3, 4'hF, hs);
    total++;
    if (first_req_cyc != hs + 1) begin bad++; $display("FAIL full_first_req: got %0d want %0d", first_req_cyc - hs, 1); end
    total++;
    if (req_addrs.size() != 4) begin bad++; $display("FAIL full_req_count: got %0d want 4", req_addrs.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++;
      if (req_addrs[i] !== 32'h1000 + 32'(4 * i)) begin
        bad++; $display("FAIL full_addr%0d: got %h want %h", i, req_addrs[i], 32'h1000 + 32'(4 * i));
      end
    end
    total++;
    if (we_cnt != 1 || we_cyc != hs + 6 || done_cyc != hs + 6) begin
      bad++; $display("FAIL full_latency: got we_cnt=%0d we_at=%0d done_at=%0d want 1/6/6", we_cnt, we_cyc - hs, done_cyc - hs);
    end
    total++;
    if (we_data !== want || we_addr !== 4'd3 || we_mask !== 4'hF || done_err !== 1'b0) begin
      bad++; $display("FAIL full_write: got d=%h a=%0d m=%h e=%b want d=%h a=3 m=f e=0", we_data, we_addr, we_mask, done_err, want);
    end
  endtask

  task automatic test_sparse();
    int hs;
    gnt_delay = 0; rsp_delay = 1; err_idx = -1;
    run_cmd(32'h2003, 4'd10, 4'b0101, hs);
    total++;
    if (req_addrs.size() != 2 || req_addrs[0] !== 32'h2000 || req_addrs[1] !== 32'h2008) begin
      bad++; $display("FAIL sparse_addrs: got n=%0d want 2000,2008", req_addrs.size());
    end
    total++;
    if (we_cnt != 1 || we_data !== model_vec(32'h2000, 4'b0101) || we_mask !== 4'b0101 || we_addr !== 4'd10) begin
      bad++; $display("FAIL sparse_write: got d=%h m=%b a=%0d want d=%h m=0101 a=10", we_data, we_mask, we_addr, model_vec(32'h2000, 4'b0101));
    end
  endtask

  task automatic test_slow_memory();
    int hs;
    logic [31:0] base;
    for (int k = 0; k < 2; k++) begin
      gnt_delay = (k == 0) ? 3 : 0; rsp_delay = (k == 0) ? 4 : 5; err_idx = -1;
      base = $urandom;
      run_cmd(base, 4'd5, 4'hF, hs);
      total++;
      if (viol != 0) begin bad++; $display("FAIL slow_addr_stable%0d: got %0d changes want 0", k, viol); end
      total++;
      if (out_max > MAX_OUT || out_max < 1) begin bad++; $display("FAIL slow_outstanding%0d: got %0d want 1..%0d", k, out_max, MAX_OUT); end
      total++;
      if (we_cnt != 1 || we_data !== model_vec(base, 4'hF)) begin
        bad++; $display("FAIL slow_data%0d: got %h want %h", k, we_data, model_vec(base, 4'hF));
      end
    end
  endtask

  task automatic test_no_traffic();
    int hs;
    gnt_delay = 0; rsp_delay = 1; err_idx = -1;
    run_cmd(32'h3000, 4'd11, 4'hF, hs);
    total++;
    if (first_req_cyc != -1 || done_cyc != hs + 1 || done_err !== 1'b1 || we_cnt != 0) begin
      bad++; $display("FAIL illegal_vd: got req_at=%0d done_at=%0d err=%b we=%0d want -1/1/1/0",
        first_req_cyc, done_cyc - hs, done_err, we_cnt);
    end
    run_cmd(32'h3000, 4'd2, 4'h0, hs);
    total++;
    if (first_req_cyc != -1 || done_cyc != hs + 1 || done_err !== 1'b0 || we_cnt != 0) begin
      bad++; $display("FAIL empty_mask: got req_at=%0d done_at=%0d err=%b we=%0d want -1/1/0/0",
        first_req_cyc, done_cyc - hs, done_err, we_cnt);
    end
  endtask

  task automatic test_bus_error();
    int hs;
    gnt_delay = 0; rsp_delay = 2; err_idx = 1;
    run_cmd(32'h4000, 4'd1, 4'hF, hs);
    total++;
    if (req_addrs.size() != 4 || rq.size() != 0) begin
      bad++; $display("FAIL err_drain: got reqs=%0d pending=%0d want 4/0", req_addrs.size(), rq.size());
    end
    total++;
    if (we_cnt != 0 || done_err !== 1'b1) begin
      bad++; $display("FAIL err_suppress: got we=%0d err=%b want 0/1", we_cnt, done_err);
    end
    err_idx = -1;
    run_cmd(32'h4100, 4'd2, 4'hF, hs);
    total++;
    if (we_cnt != 1 || done_err !== 1'b0 || we_data !== model_vec(32'h4100, 4'hF)) begin
      bad++; $display("FAIL err_recover: got we=%0d err=%b d=%h want 1/0/%h", we_cnt, done_err, we_data, model_vec(32'h4100, 4'hF));
    end
  endtask

  task automatic test_random();
    int hs, n;
    logic [31:0] base;
    logic [3:0] vd, mask;
    for (int it = 0; it < 10; it++) begin
      base = (it == 0) ? 32'hFFFF_FFFE : $urandom;
      vd = 4'($urandom_range(0, 10));
      mask = (it == 0) ? 4'hF : 4'($urandom_range(1, 15));
      gnt_delay = $urandom_range(0, 2); rsp_delay = $urandom_range(1, 4); err_idx = -1;
      run_cmd(base, vd, mask, hs);
      n = 0;
      for (int i = 0; i < 4; i++) if (mask[i]) begin
        total++;
        if (n >= req_addrs.size() || req_addrs[n] !== lane_addr(base, i)) begin
          bad++; $display("FAIL rand%0d_addr_lane%0d: got %h want %h", it, i,
            (n < req_addrs.size()) ? req_addrs[n] : 32'hX, lane_addr(base, i));
        end
        n++;
      end
      total++;
      if (req_addrs.size() != n || viol != 0 || out_max > MAX_OUT) begin
        bad++; $display("FAIL rand%0d_bus: got reqs=%0d viol=%0d max_out=%0d want %0d/0/<=%0d", it, req_addrs.size(), viol, out_max, n, MAX_OUT);
      end
      total++;
      if (we_cnt != 1 || we_addr !== vd || we_mask !== mask || we_data !== model_vec(base, mask) || done_err !== 1'b0) begin
        bad++; $display("FAIL rand%0d_write: got a=%0d m=%h d=%h want a=%0d m=%h d=%h", it, we_addr, we_mask, we_data, vd, mask, model_vec(base, mask));
      end
    end
  endtask

  task automatic test_async_reset();
    gnt_delay = 0; rsp_delay = 10; err_idx = -1;
    for (int i = 0; i < 50 && !bus.cmd_ready_o; i++) tick();
    clear_mon();
    bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = 32'h5000; bus.cmd_vd_i = 4'd4; bus.cmd_lane_mask_i = 4'b0011;
    tick();
    bus.cmd_valid_i = 1'b0;
    repeat (3) tick();
    total++;
    if (bus.busy_o !== 1'b1 || bus.data_req_o !== 1'b0 || out_cnt != 2) begin
      bad++; $display("FAIL rst_setup: got busy=%b req=%b out=%0d want 1/0/2", bus.busy_o, bus.data_req_o, out_cnt);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.data_req_o, bus.vrf_we_o, bus.busy_o, bus.done_o, bus.err_o} !== 5'b0 ||
        {bus.data_addr_o, bus.vrf_waddr_o, bus.vrf_wmask_o, bus.vrf_wdata_o} !== '0) begin
      bad++; $display("FAIL rst_async: got req=%b we=%b busy=%b addr=%h want all 0",
        bus.data_req_o, bus.vrf_we_o, bus.busy_o, bus.data_addr_o);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30 && rq.size() != 0; i++) tick();
    repeat (3) tick();
    out_cnt = 0;
    total++;
    if (we_cnt != 0 || done_cnt != 0 || bus.cmd_ready_o !== 1'b1) begin
      bad++; $display("FAIL rst_late_rsp: got we=%0d done=%0d ready=%b want 0/0/1", we_cnt, done_cnt, bus.cmd_ready_o);
    end
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_vd_i = '0; bus.cmd_lane_mask_i = '0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_full_mask();
    test_sparse();
    test_slow_memory();
    test_no_traffic();
    test_bus_error();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
